// File: rtl/fir_mac_pkg.sv
// Shared types, reset coefficients and arithmetic helpers for the time-multiplexed FIR sequencer.
package fir_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Reset tap weights h0..h7; larger banks repeat the pattern.
    localparam int COEF_RST [8] = '{-2, -1, 3, 4, 1, 1, 1, 1};

    function automatic int calc_aw(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// NTAPS x CW coefficient registers: async reset to defaults, gated write, combinational read.
// Write lands on the clock edge; read reflects the current register contents.
module fir_coef_bank
    import fir_mac_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int CW    = 8
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(NTAPS)-1:0]   wr_addr,
    input  logic signed [CW-1:0]       wr_data,
    input  logic [$clog2(NTAPS)-1:0]   rd_addr,
    output logic signed [CW-1:0]       rd_data
);

    logic signed [CW-1:0] coef_q [NTAPS];
    logic signed [CW-1:0] coef_d [NTAPS];

    always_comb begin
        coef_d = coef_q;
        if (wr_en)
            coef_d[wr_addr] = wr_data;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                coef_q[i] <= CW'(COEF_RST[i % 8]);
        end else begin
            coef_q <= coef_d;
        end
    end

    assign rd_data = coef_q[rd_addr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// 8-tap signed FIR on one shared MAC; out_valid rises NTAPS edges after accept, result held until out_ready.
// in_ready only in IDLE, coefficient writes only land in IDLE. FIR_MAC_SAT_EN saturates instead of wrapping.
module fir_mac_sequencer
    import fir_mac_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 16
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DW-1:0]       Xin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OW-1:0]       Yout,
    input  logic                       cfg_we,
    input  logic [$clog2(NTAPS)-1:0]   cfg_addr,
    input  logic signed [CW-1:0]       cfg_data,
    output logic                       busy
);

    localparam int AW = calc_aw(DW, CW, NTAPS);
    localparam int KW = $clog2(NTAPS);
    localparam int PW = DW + CW;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] hist_q [NTAPS];
    logic signed [DW-1:0] hist_d [NTAPS];
    logic signed [OW-1:0] yout_q, yout_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic signed [CW-1:0] coef_k;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum;
`ifdef FIR_MAC_SAT_EN
    logic signed [63:0]   sat_v;
`endif

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW)
    ) u_coef_bank (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .wr_en   (cfg_we && (state_q == IDLE)),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (k_q),
        .rd_data (coef_k)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        hist_d      = hist_q;
        yout_d      = yout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        prod        = coef_k * hist_q[k_q];
        sum         = acc_q + {{(AW - PW){prod[PW-1]}}, prod};
`ifdef FIR_MAC_SAT_EN
        sat_v       = saturate(64'(sum), OW);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    hist_d[0] = Xin;
                    for (int i = 1; i < NTAPS; i++)
                        hist_d[i] = hist_q[i-1];
                    acc_d      = '0;
                    k_d        = '0;
                    state_d    = MAC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            MAC: begin
                acc_d = sum;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(NTAPS - 1)) begin
`ifdef FIR_MAC_SAT_EN
                    yout_d = sat_v[OW-1:0];
`else
                    yout_d = sum[OW-1:0];
`endif
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            for (int i = 0; i < NTAPS; i++)
                hist_q[i] <= '0;
            yout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            hist_q      <= hist_d;
            yout_q      <= yout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Yout      = yout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: impulse, coefficient writes, wrap/saturate, backpressure, reset, throughput.
module tb_fir_mac_sequencer;

    logic               Clk;
    logic               Rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  Xin;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] Yout;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic signed [7:0]  cfg_data;
    logic               busy;

    int vecs = 0;
    int miss = 0;

    fir_mac_sequencer dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xin       (Xin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Yout      (Yout),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Offer one sample, optionally attempt a coefficient write while busy, and check the result.
    task automatic run_sample(input logic signed [7:0] x, input int exp_y, input string tag, input bit busy_wr);
        int  n;
        bit  rdy_seen;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        Xin      = x;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        if (busy_wr) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'd0;
            cfg_data = 8'sd7;
        end
        n = 0;
        rdy_seen = 1'b0;
        while (!out_valid && n < 50) begin
            if (in_ready)
                rdy_seen = 1'b1;
            step();
            cfg_we = 1'b0;
            n++;
        end
        if (in_ready)
            rdy_seen = 1'b1;
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_y"}, Yout, exp_y);
        chk({tag, "_rdylow"}, rdy_seen, 0);
        step();
        chk({tag, "_exit"}, {in_ready, out_valid}, 2'b10);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    int imp_exp [9] = '{-2, -1, 3, 4, 1, 1, 1, 1, 0};
    int cw_exp  [9] = '{-2, -1, 3, -5, 1, 1, 1, 1, 0};
`ifdef FIR_MAC_SAT_EN
    int wrap_exp [8] = '{-16256, -32512, -32768, -32768, -32768, -32768, -32768, -32768};
    int bp_exp2 = -32768;
`else
    int wrap_exp [8] = '{-16256, -32512, 16768, 512, -15744, -32000, 17280, 1024};
    int bp_exp2 = 17915;
`endif
    int dflt_coef [8] = '{-2, -1, 3, 4, 1, 1, 1, 1};

    initial begin
        int n;
        int idx;
        int last;
        int cyc;
        int outs;
        int e;
        bit acc_now;
        logic signed [15:0] e16;
        logic signed [7:0]  tx;
        int mh [8];
        int expq [$];

        Rst_n     = 1'b0;
        in_valid  = 1'b0;
        Xin       = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;

        #12;
        chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
        chk("rst_yout", Yout, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        chk("post_rst_idle", {in_ready, busy}, 2'b10);

        // Impulse response with default coefficients.
        for (int i = 0; i < 9; i++)
            run_sample((i == 0) ? 8'sd1 : 8'sd0, imp_exp[i], $sformatf("imp%0d", i), 1'b0);

        // IDLE write lands; busy write on tap 0 is dropped.
        write_coef(3'd3, -8'sd5);
        for (int i = 0; i < 9; i++)
            run_sample((i == 0) ? 8'sd1 : 8'sd0, cw_exp[i], $sformatf("cw%0d", i), i == 0);

        // Full-scale products: wrap or saturate at the output load.
        for (int j = 0; j < 8; j++)
            write_coef(3'(j), 8'sd127);
        for (int i = 0; i < 8; i++)
            run_sample(-8'sd128, wrap_exp[i], $sformatf("wrap%0d", i), 1'b0);

        // Backpressure: result held while out_ready is low; offered sample waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Xin       = -8'sd128;
        step();
        Xin = 8'sd5;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("bp_lat", n, 8);
        chk("bp_y", Yout, wrap_exp[7]);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_ctl%0d", i), {out_valid, in_ready, busy}, 3'b101);
            chk($sformatf("bp_hold_y%0d", i), Yout, wrap_exp[7]);
        end
        out_ready = 1'b1;
        step();
        chk("bp_exit", {in_ready, out_valid}, 2'b10);
        step();
        in_valid = 1'b0;
        chk("bp_accept", {in_ready, busy}, 2'b01);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("bp2_lat", n, 8);
        chk("bp2_y", Yout, bp_exp2);
        step();

        // Asynchronous reset in the middle of MAC.
        in_valid = 1'b1;
        Xin      = 8'sd1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_busy", busy, 1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {in_ready, out_valid, busy}, 3'b100);
        chk("mid_rst_y", Yout, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        run_sample(8'sd1, -2, "rst_imp0", 1'b0);
        run_sample(8'sd0, -1, "rst_imp1", 1'b0);

        // Throughput: continuous offer and sink, checked against a reference model.
        Rst_n = 1'b0;
        #2;
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++)
            mh[i] = 0;
        in_valid = 1'b1;
        idx  = 0;
        last = 0;
        cyc  = 0;
        outs = 0;
        while ((idx < 20 || outs < 20) && cyc < 400) begin
            tx = 8'((idx * 37 + 11) % 256 - 128);
            if (idx < 20)
                Xin = tx;
            else
                in_valid = 1'b0;
            acc_now = in_ready && in_valid;
            if (out_valid) begin
                if (expq.size() == 0)
                    chk("tp_extra", out_valid, 0);
                else
                    chk($sformatf("tp_y%0d", outs), Yout, expq.pop_front());
                outs++;
            end
            step();
            cyc++;
            if (acc_now) begin
                for (int k = 7; k > 0; k--)
                    mh[k] = mh[k-1];
                mh[0] = tx;
                e = 0;
                for (int k = 0; k < 8; k++)
                    e += dflt_coef[k] * mh[k];
                e16 = 16'(e);
                expq.push_back(e16);
                if (idx > 0)
                    chk($sformatf("tp_gap%0d", idx), cyc - last, 10);
                last = cyc;
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("tp_accepts", idx, 20);
        chk("tp_outputs", outs, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
